w_shift_tx: RTL

- Serial word transmitter that drives a 4-bit universal shift register, such as W_74HC194, used as a serial-in/parallel-out receiver.
- Accepts a parallel word over a valid/ready handshake and serializes it one bit per clock onto the receiver's right-shift or left-shift serial input.
- Generates the receiver's mode-select lines so the word lands in the same bit order at the far end.
- Pulses a done strobe when the receiver holds the complete word.

---
 rtl/w_shift_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/w_shift_tx.sv
// Serial word transmitter feeding a 4-bit universal shift register (74HC194 style)
// used as a serial-in/parallel-out receiver; the word lands at the far end in DIN bit order.
module w_shift_tx #(
  parameter int WIDTH    = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic             CLK,
  input  logic             MR_N,
  input  logic [0:WIDTH-1] DIN,
  input  logic             DIN_VALID,
  input  logic             DIR,
  output logic             DIN_READY,
  output logic [1:0]       S_OUT,
  output logic             SDR,
  output logic             SDL,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a word transfers on a rising edge where DIN_VALID and DIN_READY are both 1;
  // DIN_READY is high only in IDLE, and DIN/DIR are captured on that edge.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc, w_idx;
  logic [3:0]       r_gap, w_gap_nxt;
  logic [0:WIDTH-1] r_word, w_word_nxt;
  logic             r_dir, w_dir_nxt;
  logic [1:0]       r_s, w_s_nxt;
  logic             r_sdr, w_sdr_nxt;
  logic             r_sdl, w_sdl_nxt;
  logic             r_done, w_done_nxt;
  logic             w_bit;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_word  <= '0;
      r_dir   <= 1'b0;
      r_s     <= 2'b00;
      r_sdr   <= 1'b0;
      r_sdl   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_word  <= w_word_nxt;
      r_dir   <= w_dir_nxt;
      r_s     <= w_s_nxt;
      r_sdr   <= w_sdr_nxt;
      r_sdl   <= w_sdl_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_word_nxt  = r_word;
    w_dir_nxt   = r_dir;
    w_s_nxt     = 2'b00;
    w_sdr_nxt   = 1'b0;
    w_sdl_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_idx       = '0;
    w_bit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (DIN_VALID) begin
          w_word_nxt  = DIN;
          w_dir_nxt   = DIR;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
          // First bit goes out on the accept edge, straight from the bus.
          if (DIR) begin
            w_s_nxt   = 2'b10;
            w_sdl_nxt = DIN[0];
          end else begin
            w_s_nxt   = 2'b01;
            w_sdr_nxt = DIN[WIDTH-1];
          end
        end
      end
      ST_SHIFT: begin
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          // Right shift sends MSB-index first so it ends up at Q3; left shift the reverse.
          w_idx = r_dir ? w_cnt_inc : (LAST_BIT - w_cnt_inc);
          w_bit = r_word[w_idx];
          if (r_dir) begin
            w_s_nxt   = 2'b10;
            w_sdl_nxt = w_bit;
          end else begin
            w_s_nxt   = 2'b01;
            w_sdr_nxt = w_bit;
          end
        end
      end
      ST_DONE: begin
        w_gap_nxt = '0;
        if (IDLE_GAP > 0) w_state_nxt = ST_GAP;
        else              w_state_nxt = ST_IDLE;
      end
      ST_GAP: begin
        w_gap_nxt = r_gap + 1'b1;
        if (r_gap == GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign DIN_READY   = (r_state == ST_IDLE);
  assign BUSY        = (r_state != ST_IDLE);
  assign S_OUT       = r_s;
  assign SDR         = r_sdr;
  assign SDL         = r_sdl;
  assign FRAME_DONE  = r_done;
  assign o_dbg_state = r_state;

endmodule
